// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants and helpers for the load/store initiator.
//               This covers the memory access type codes, the FSM state codes,
//               the request classification codes and the beat count function.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access type codes, shared by the core request and the memory interface
    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    // Controller states
    localparam int         c_STATE_W = 2;
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_RESP    = 2'd2;

    // Request classification, decided when the request is accepted
    localparam logic [1:0] c_KIND_ALIGNED = 2'd0;
    localparam logic [1:0] c_KIND_SPLIT   = 2'd1;
    localparam logic [1:0] c_KIND_ERR     = 2'd2;

    // Number of byte beats a split access of the given size code needs
    function automatic logic [2:0] beats_for_type(input logic [1:0] size_code);
        case (size_code)
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_extend
// Description : Combinational extension of assembled load data. Byte and
//               halfword loads are sign- or zero-extended by type. Word data
//               passes through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_type,
    output logic [31:0] o_data
);

    // Pick the extension rule from the access type
    always_comb begin
        o_data = i_data;
        case (i_type)
            RW_B:    o_data = {{24{i_data[7]}}, i_data[7:0]};
            RW_BU:   o_data = {24'h000000, i_data[7:0]};
            RW_H:    o_data = {{16{i_data[15]}}, i_data[15:0]};
            RW_HU:   o_data = {16'h0000, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_initiator
// Description : Load/store initiator between the execute stage and the data
//               memory. An aligned access is sent as one memory beat. A
//               misaligned halfword or word access is split into unsigned
//               byte beats, then the bytes are reassembled and extended.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int SPLIT_EN = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_W_en,
    output logic              mem_R_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_RW_type,
    output logic [31:0]       mem_WD,
    input  logic [31:0]       mem_RD
);

    logic [c_STATE_W-1:0] r_state;
    logic [1:0]           r_kind;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [2:0]           r_type;
    logic [31:0]          r_wdata;
    logic [2:0]           r_beat;
    logic [2:0]           r_last;
    logic [31:0]          r_asm;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_err;

    logic                 w_bad_type;
    logic                 w_misaligned;
    logic [1:0]           w_req_kind;
    logic [2:0]           w_req_type_eff;
    logic [2:0]           w_req_last;
    logic                 w_active;
    logic                 w_split;
    logic                 w_done_beat;
    logic [ADDR_W-1:0]    w_beat_addr;
    logic [7:0]           w_wbyte;
    logic [31:0]          w_asm_next;
    logic [31:0]          w_ext;
    logic [31:0]          w_load_result;

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Type codes with low bits 11, and 110, have no meaning.
    assign w_bad_type   = (req_type[1:0] == 2'b11) || (req_type == 3'b110);
    assign w_misaligned = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_type[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // A store ignores the unsigned bit of the type.
    assign w_req_type_eff = req_we ? {1'b0, req_type[1:0]} : req_type;

    // Classify the incoming request as error, aligned or split
    always_comb begin
        w_req_kind = c_KIND_ALIGNED;
        w_req_last = 3'd0;
        if (w_bad_type || (w_misaligned && (SPLIT_EN == 0))) begin
            w_req_kind = c_KIND_ERR;
        end else if (w_misaligned) begin
            w_req_kind = c_KIND_SPLIT;
            w_req_last = beats_for_type(req_type[1:0]) - 3'd1;
        end
    end

    // An error request still spends one ISSUE cycle, but it never touches memory.
    assign w_active    = (r_state == c_ISSUE) && (r_kind != c_KIND_ERR);
    assign w_split     = (r_kind == c_KIND_SPLIT);
    assign w_done_beat = !w_split || (r_beat == r_last);
    assign w_beat_addr = r_addr + {{(ADDR_W-3){1'b0}}, r_beat};

    // Select the store byte for the current split beat
    always_comb begin
        w_wbyte = r_wdata[7:0];
        case (r_beat[1:0])
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            2'd3:    w_wbyte = r_wdata[31:24];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    // Merge the byte returned on this beat into the assembly register image
    always_comb begin
        w_asm_next = r_asm;
        case (r_beat[1:0])
            2'd1:    w_asm_next[15:8]  = mem_RD[7:0];
            2'd2:    w_asm_next[23:16] = mem_RD[7:0];
            2'd3:    w_asm_next[31:24] = mem_RD[7:0];
            default: w_asm_next[7:0]   = mem_RD[7:0];
        endcase
    end

    lsu_load_extend u_load_extend (
        .i_data (w_asm_next),
        .i_type (r_type),
        .o_data (w_ext)
    );

    // Aligned loads use the memory's own extended data. Split loads are
    // assembled and then extended locally.
    assign w_load_result = (r_we || (r_kind == c_KIND_ERR)) ? 32'h0 :
                           (w_split ? w_ext : mem_RD);

    // Drive the memory interface from registered state only, so an async reset drops it at once
    always_comb begin
        mem_W_en    = 1'b0;
        mem_R_en    = 1'b0;
        mem_addr    = '0;
        mem_RW_type = 3'b000;
        mem_WD      = 32'h0;
        if (w_active) begin
            mem_W_en = r_we;
            mem_R_en = !r_we;
            if (w_split) begin
                mem_addr    = w_beat_addr;
                mem_RW_type = r_we ? RW_B : RW_BU;
                mem_WD      = r_we ? {24'h000000, w_wbyte} : 32'h0;
            end else begin
                mem_addr    = r_addr;
                mem_RW_type = r_type;
                mem_WD      = r_we ? r_wdata : 32'h0;
            end
        end
    end

    // Controller: capture in IDLE, step beats in ISSUE, pulse the response in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_kind      <= c_KIND_ALIGNED;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_type      <= 3'b000;
            r_wdata     <= 32'h0;
            r_beat      <= 3'd0;
            r_last      <= 3'd0;
            r_asm       <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_kind  <= w_req_kind;
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_type  <= w_req_type_eff;
                        r_wdata <= req_wdata;
                        r_beat  <= 3'd0;
                        r_last  <= w_req_last;
                        r_asm   <= 32'h0;
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_split) begin
                        r_asm <= w_asm_next;
                    end
                    if (w_done_beat) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= (r_kind == c_KIND_ERR);
                        r_rsp_rdata <= w_load_result;
                        r_state     <= c_RESP;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                c_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                    r_state     <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_initiator
// Description : Self-checking bench for lsu_mem_initiator. It uses a byte-level
//               memory model and a reference byte image of the memory. It runs
//               directed scenarios, then randomized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        drv_valid = 1'b0;
    logic        use_ns = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] mem_rd = 32'h0;

    logic        req_ready, rsp_valid, rsp_err, mem_W_en, mem_R_en;
    logic [31:0] rsp_rdata, mem_addr, mem_WD;
    logic [2:0]  mem_RW_type;

    logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_mem_W_en, ns_mem_R_en;
    logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_WD;
    logic [2:0]  ns_mem_RW_type;

    logic        s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_rdata;
    assign s_req_ready = use_ns ? ns_req_ready : req_ready;
    assign s_rsp_valid = use_ns ? ns_rsp_valid : rsp_valid;
    assign s_rsp_err   = use_ns ? ns_rsp_err   : rsp_err;
    assign s_rsp_rdata = use_ns ? ns_rsp_rdata : rsp_rdata;

    int n_cmp = 0;
    int n_mis = 0;
    int ns_en_cnt = 0;
    logic [31:0] last_rd;

    logic [7:0] dmem [logic [31:0]];
    logic [7:0] rmem [logic [31:0]];

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [2:0]  t;
        logic [31:0] wd;
    } beat_t;
    beat_t beats[$];

    always #5 clk = ~clk;

    lsu_mem_initiator #(.SPLIT_EN(1), .ADDR_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(drv_valid && !use_ns), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
        .mem_RW_type(mem_RW_type), .mem_WD(mem_WD), .mem_RD(mem_rd)
    );

    lsu_mem_initiator #(.SPLIT_EN(0), .ADDR_W(32)) u_dut_ns (
        .clk(clk), .rst_n(rst_n),
        .req_valid(drv_valid && use_ns), .req_ready(ns_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err),
        .mem_W_en(ns_mem_W_en), .mem_R_en(ns_mem_R_en), .mem_addr(ns_mem_addr),
        .mem_RW_type(ns_mem_RW_type), .mem_WD(ns_mem_WD), .mem_RD(32'hA5A5A5A5)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        case (t[1:0])
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] t);
        case (t)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b100:  return {24'h0, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b101:  return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [7:0] dbyte(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    // Memory device behaviour: typed little-endian read at any byte address
    function automatic logic [31:0] dev_read(input logic [31:0] a, input logic [2:0] t);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < nbytes(t); k++) v[8*k +: 8] = dbyte(a + 32'(k));
        return extend(v, t);
    endfunction

    // Reference: the value a load of this type should return, from the expected byte image
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < nbytes(t); k++) v[8*k +: 8] = rbyte(a + 32'(k));
        return extend(v, t);
    endfunction

    // Memory model and beat monitor, evaluated mid-cycle while the DUT outputs are stable
    always @(negedge clk) begin
        if (mem_W_en || mem_R_en) beats.push_back('{mem_addr, mem_W_en, mem_RW_type, mem_WD});
        if (mem_W_en)
            for (int k = 0; k < nbytes(mem_RW_type); k++) dmem[mem_addr + 32'(k)] = mem_WD[8*k +: 8];
        mem_rd = dev_read(mem_addr, mem_RW_type);
        if (ns_mem_W_en || ns_mem_R_en) ns_en_cnt++;
    end

    task automatic run_req(input bit ns, input logic we, input logic [31:0] addr,
                           input logic [2:0] typ, input logic [31:0] wd, input bit poke);
        int n, nb, lat, exp_lat;
        bit err, mis, split;
        logic [31:0] exp_rd, exp_wd;
        logic [2:0] exp_t;
        n     = nbytes(typ);
        err   = (typ[1:0] == 2'b11) || (typ == 3'b110);
        mis   = (addr % n) != 0;
        if (mis && ns) err = 1'b1;
        split = !err && mis;
        nb    = err ? 0 : (split ? n : 1);
        exp_lat = (split ? n : 1) + 1;
        exp_rd  = (we || err) ? 32'h0 : ref_load(addr, typ);

        @(negedge clk);
        use_ns = ns;
        beats.delete();
        #1;
        chk("ready_idle", {31'h0, s_req_ready}, 32'h1);
        req_we = we; req_addr = addr; req_type = typ; req_wdata = wd; drv_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        chk("ready_busy", {31'h0, s_req_ready}, 32'h0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (poke) drv_valid = (lat == 1 || lat == 2);
        end while (!s_rsp_valid && lat < 12);
        drv_valid = 1'b0;

        chk("latency", lat, exp_lat);
        chk("rsp_err", {31'h0, s_rsp_err}, {31'h0, err});
        chk("rsp_rdata", s_rsp_rdata, exp_rd);
        chk("beat_count", beats.size(), nb);
        for (int k = 0; k < nb && k < beats.size(); k++) begin
            exp_t  = split ? (we ? 3'b000 : 3'b100) : (we ? {1'b0, typ[1:0]} : typ);
            exp_wd = split ? {24'h0, wd[8*k +: 8]} : wd;
            chk("beat_addr", beats[k].a, addr + 32'(k));
            chk("beat_we", {31'h0, beats[k].we}, {31'h0, we});
            chk("beat_type", {29'h0, beats[k].t}, {29'h0, exp_t});
            if (we) chk("beat_wd", beats[k].wd, exp_wd);
        end
        last_rd = s_rsp_rdata;
        if (we && !err)
            for (int k = 0; k < n; k++) rmem[addr + 32'(k)] = wd[8*k +: 8];
        @(negedge clk);
        chk("rsp_pulse", {31'h0, s_rsp_valid}, 32'h0);
    endtask

    initial begin
        logic [2:0] ttab [10];
        ttab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wen", {31'h0, mem_W_en}, 32'h0);
        chk("rst_ren", {31'h0, mem_R_en}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'h0, req_ready}, 32'h1);
        chk("rel_rdata", rsp_rdata, 32'h0);
        chk("rel_err", {31'h0, rsp_err}, 32'h0);

        // Aligned store then load
        run_req(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0);
        run_req(0, 1'b0, 32'h10, 3'b010, 32'h0, 0);
        chk("lw_deadbeef", last_rd, 32'hDEADBEEF);

        // Misaligned word store split into bytes, read back aligned
        run_req(0, 1'b1, 32'h21, 3'b010, 32'h11223344, 0);
        run_req(0, 1'b0, 32'h20, 3'b010, 32'h0, 0);
        chk("lw_20", last_rd, 32'h22334400);

        // Misaligned halfword loads, signed and unsigned
        run_req(0, 1'b1, 32'h23, 3'b000, 32'h00000034, 0);
        run_req(0, 1'b1, 32'h24, 3'b100, 32'h00000092, 0);
        run_req(0, 1'b0, 32'h23, 3'b001, 32'h0, 0);
        chk("lh_23", last_rd, 32'hFFFF9234);
        run_req(0, 1'b0, 32'h23, 3'b101, 32'h0, 0);
        chk("lhu_23", last_rd, 32'h00009234);

        // Errors on the non-splitting instance
        run_req(1, 1'b0, 32'h10, 3'b011, 32'h0, 0);
        run_req(1, 1'b0, 32'h02, 3'b010, 32'h0, 0);
        run_req(0, 1'b1, 32'h30, 3'b011, 32'hCAFEF00D, 0);

        // Address wrap, with request pokes while busy
        run_req(0, 1'b1, 32'hFFFFFFFE, 3'b010, 32'h8899AABB, 0);
        run_req(0, 1'b0, 32'hFFFFFFFE, 3'b010, 32'h0, 1);
        chk("lw_wrap", last_rd, 32'h8899AABB);

        // Reset during the third beat of a split store
        @(negedge clk);
        use_ns = 1'b0; beats.delete();
        req_we = 1'b1; req_addr = 32'h21; req_type = 3'b010; req_wdata = 32'hA1B2C3D4; drv_valid = 1'b1;
        @(posedge clk);
        #1 drv_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_wen", {31'h0, mem_W_en}, 32'h1);
        chk("mid_addr", mem_addr, 32'h23);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_wen", {31'h0, mem_W_en}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {31'h0, rsp_valid}, 32'h0);
        end
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
        chk("byte_21", {24'h0, dbyte(32'h21)}, 32'hD4);
        chk("byte_22", {24'h0, dbyte(32'h22)}, 32'hC3);
        chk("byte_23", {24'h0, dbyte(32'h23)}, 32'h34);
        rmem[32'h21] = 8'hD4;
        rmem[32'h22] = 8'hC3;

        // Randomized traffic in a small window
        for (int i = 0; i < 60; i++) begin
            run_req(0, 1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 15)),
                    ttab[$urandom_range(0, 9)], $urandom, 0);
        end
        for (int a = 32'h40; a < 32'h54; a++)
            chk("mem_final", {24'h0, dbyte(32'(a))}, {24'h0, rbyte(32'(a))});
        chk("ns_no_enables", ns_en_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
